fifo_rd_burst: RTL and testbench



---
 rtl/fifo_rd_burst_pkg.sv | 7 +
 rtl/fifo_rd_skid.sv | 44 ++++
 rtl/fifo_rd_burst.sv | 84 ++++++++
 tb/tb_fifo_rd_burst.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_burst_pkg.sv
// fifo_rd_burst_pkg: FSM encoding and skid buffer sizing shared by the FIFO read burst controller
package fifo_rd_burst_pkg;
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    localparam int SKID_DEPTH = 4;
    localparam int SKID_CW    = 3;
    localparam int SKID_AW    = 2;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 4-entry single-clock buffer absorbing FIFO read latency and stream backpressure
module fifo_rd_skid
    import fifo_rd_burst_pkg::*;
#(
    parameter int kuan = 16
) (
    input  logic               rdclk,
    input  logic               aclr,
    input  logic               push,
    input  logic               pop,
    input  logic [kuan-1:0]    din,
    output logic [SKID_CW-1:0] count,
    output logic [kuan-1:0]    head
);
    logic [kuan-1:0]    mem_q [SKID_DEPTH];
    logic [kuan-1:0]    mem_d [SKID_DEPTH];
    logic [SKID_AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [SKID_CW-1:0] cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = din;
        wp_d  = push ? wp_q + 1'b1 : wp_q;
        rp_d  = pop ? rp_q + 1'b1 : rp_q;
        cnt_d = cnt_q + SKID_CW'(push) - SKID_CW'(pop);
    end

    always_ff @(posedge rdclk or negedge aclr) begin
        if (!aclr) begin
            mem_q <= '{default: '0};
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;
    assign head  = mem_q[rp_q];
endmodule

// File: rtl/fifo_rd_burst.sv
// fifo_rd_burst: waits for a full burst in the FIFO, then drains blen words onto a valid/ready stream
module fifo_rd_burst
    import fifo_rd_burst_pkg::*;
#(
    parameter int kuan    = 16,
    parameter int shenbit = 11,
    parameter int blen    = 64
) (
    input  logic               rdclk,
    input  logic               aclr,
    input  logic               en,
    output logic               rdreq,
    input  logic [kuan-1:0]    q,
    input  logic [shenbit-1:0] rdusedw,
    input  logic               rdempty,
    output logic [kuan-1:0]    m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last,
    output logic               busy,
    output logic               burst_done
);
    localparam logic [shenbit-1:0] BLEN = shenbit'(blen);
    localparam logic [shenbit-1:0] LAST = shenbit'(blen - 1);

    state_t             state_q, state_d;
    logic [shenbit-1:0] rem_q, rem_d, dlv_q, dlv_d;
    logic               rd_d1_q;
    logic [SKID_CW-1:0] cnt;
    logic               pop;
    logic               unused_rdempty;

    assign unused_rdempty = rdempty;

    fifo_rd_skid #(.kuan(kuan)) u_skid (
        .rdclk (rdclk),
        .aclr  (aclr),
        .push  (rd_d1_q),
        .pop   (pop),
        .din   (q),
        .count (cnt),
        .head  (m_data)
    );

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        dlv_d      = dlv_q;
        m_valid    = cnt != '0;
        m_last     = m_valid && dlv_q == LAST;
        pop        = m_valid && m_ready;
        burst_done = pop && m_last && state_q == DRAIN;
        busy       = state_q != IDLE;
        // the in-flight read counts against buffer space, so the buffer can never overflow
        rdreq      = state_q == BURST && rem_q != '0 && int'(cnt) + int'(rd_d1_q) < SKID_DEPTH;
        if (state_q == IDLE && en && rdusedw >= BLEN) begin
            state_d = BURST;
            rem_d   = BLEN;
        end
        if (rdreq) begin
            rem_d   = rem_q - 1'b1;
            state_d = rem_q == shenbit'(1) ? DRAIN : state_q;
        end
        if (pop) dlv_d = dlv_q + 1'b1;
        if (burst_done) begin
            state_d = IDLE;
            dlv_d   = '0;
        end
    end

    always_ff @(posedge rdclk or negedge aclr) begin
        if (!aclr) begin
            state_q <= IDLE;
            rem_q   <= '0;
            dlv_q   <= '0;
            rd_d1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            dlv_q   <= dlv_d;
            rd_d1_q <= rdreq;
        end
    end
endmodule

// File: tb/tb_fifo_rd_burst.sv
// tb_fifo_rd_burst: table-driven and directed checks of the FIFO read burst controller (blen 64 and blen 1)
module tb_fifo_rd_burst;
    localparam int KUAN = 16;
    localparam int SB   = 11;

    typedef struct {
        logic en;
        int   occ;
        logic start;
    } vec_t;

    logic            rdclk = 1'b0;
    logic            aclr = 1'b0;
    logic            en = 1'b0, en_b = 1'b0;
    logic            m_ready = 1'b1, m_ready_b = 1'b1;
    logic            rdreq, rdreq_b, m_valid, m_valid_b, m_last, m_last_b;
    logic            busy, busy_b, burst_done, burst_done_b, rdempty, rdempty_b;
    logic [KUAN-1:0] q, q_b, m_data, m_data_b;
    logic [SB-1:0]   rdusedw, rdusedw_b;
    int              fill = 0, fill_b = 0, nrd, nrd_b;
    int              n_cmp = 0, n_bad = 0, rmode = 0;
    int              n_rd = 0, n_dlv = 0, n_done = 0, bw = 0;
    int              n_rd_b = 0, n_dlv_b = 0, n_done_b = 0;
    int              r0, d0, b0;
    vec_t            vec [8];

    always #5 rdclk = ~rdclk;

    function automatic logic [KUAN-1:0] word(input int i);
        return KUAN'(i) ^ 16'hA5C3;
    endfunction

    always @(posedge rdclk or negedge aclr)
        if (!aclr) begin
            nrd <= 0;
            q   <= '0;
        end else if (rdreq) begin
            q   <= word(nrd);
            nrd <= nrd + 1;
        end

    always @(posedge rdclk or negedge aclr)
        if (!aclr) begin
            nrd_b <= 0;
            q_b   <= '0;
        end else if (rdreq_b) begin
            q_b   <= word(nrd_b);
            nrd_b <= nrd_b + 1;
        end

    assign rdusedw   = SB'(fill - nrd);
    assign rdusedw_b = SB'(fill_b - nrd_b);
    assign rdempty   = rdusedw == '0;
    assign rdempty_b = rdusedw_b == '0;

    fifo_rd_burst #(.kuan(KUAN), .shenbit(SB), .blen(64)) u_a (
        .rdclk(rdclk), .aclr(aclr), .en(en), .rdreq(rdreq), .q(q), .rdusedw(rdusedw),
        .rdempty(rdempty), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_last(m_last), .busy(busy), .burst_done(burst_done)
    );

    fifo_rd_burst #(.kuan(KUAN), .shenbit(SB), .blen(1)) u_b (
        .rdclk(rdclk), .aclr(aclr), .en(en_b), .rdreq(rdreq_b), .q(q_b), .rdusedw(rdusedw_b),
        .rdempty(rdempty_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready_b),
        .m_last(m_last_b), .busy(busy_b), .burst_done(burst_done_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        logic hs, hs_b;
        @(negedge rdclk);
        m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? 1'($urandom_range(0, 1)) : 1'b0;
        #1;
        hs   = m_valid && m_ready;
        hs_b = m_valid_b && m_ready_b;
        if (rdreq) begin
            n_rd++;
            chk("rd_on_empty", int'(rdempty && rdusedw == '0), 0);
        end
        if (rdreq_b) begin
            n_rd_b++;
            chk("b_rd_on_empty", int'(rdempty_b && rdusedw_b == '0), 0);
        end
        chk("done_pulse", burst_done, int'(hs && bw == 63));
        chk("b_done_pulse", burst_done_b, hs_b);
        if (hs) begin
            chk("data_order", m_data, word(n_dlv));
            chk("last_flag", m_last, int'(bw == 63));
            n_dlv++;
            bw = bw == 63 ? 0 : bw + 1;
        end
        if (hs_b) begin
            chk("b_data_order", m_data_b, word(n_dlv_b));
            chk("b_last_flag", m_last_b, 1);
            n_dlv_b++;
        end
        if (burst_done) n_done++;
        if (burst_done_b) n_done_b++;
        chk("outstanding_le4", int'(n_rd - n_dlv <= 4), 1);
    endtask

    task automatic wait_idle(input int lim);
        for (int k = 0; k < lim && busy; k++) cyc();
        chk("idle_in_time", busy, 0);
    endtask

    task automatic wait_dlv(input int target, input int lim);
        for (int k = 0; k < lim && n_dlv < target; k++) cyc();
        chk("dlv_in_time", int'(n_dlv >= target), 1);
    endtask

    task automatic do_reset(input int ncyc, input logic rnd);
        aclr = 1'b0;
        fill = 0;
        fill_b = 0;
        n_rd = 0; n_dlv = 0; n_done = 0; bw = 0;
        n_rd_b = 0; n_dlv_b = 0; n_done_b = 0;
        for (int k = 0; k < ncyc; k++) begin
            if (rnd) begin
                en     = 1'($urandom_range(0, 1));
                en_b   = 1'($urandom_range(0, 1));
                fill   = $urandom_range(0, 2047);
                fill_b = $urandom_range(0, 2047);
                rmode  = 1;
            end
            cyc();
            chk("rst_rdreq", rdreq, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            chk("rst_busy", busy, 0);
            chk("rst_burst_done", burst_done, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_b_outputs", int'({rdreq_b, m_valid_b, m_last_b, busy_b, burst_done_b}), 0);
            chk("rst_b_m_data", m_data_b, 0);
        end
        en = 1'b0; en_b = 1'b0; fill = 0; fill_b = 0; rmode = 0;
        aclr = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec = '{'{1'b1, 63, 1'b0}, '{1'b1, 64, 1'b1}, '{1'b0, 2000, 1'b0}, '{1'b1, 0, 1'b0},
                '{1'b1, 2047, 1'b1}, '{1'b0, 64, 1'b0}, '{1'b1, 65, 1'b1}, '{1'b1, 1000, 1'b1}};
        do_reset(5, 1'b1);

        for (int i = 0; i < 8; i++) begin
            en   = vec[i].en;
            fill = nrd + vec[i].occ;
            cyc();
            chk($sformatf("vec%0d_rdreq", i), rdreq, vec[i].start);
            chk($sformatf("vec%0d_busy", i), busy, vec[i].start);
            en = 1'b0;
            wait_idle(300);
        end

        en = 1'b1;
        fill = nrd + 63;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("below_thr_rdreq", rdreq, 0);
        end
        fill = nrd + 64;
        r0 = n_rd; d0 = n_dlv; b0 = n_done;
        for (int i = 0; i < 64; i++) begin
            cyc();
            chk("rdreq_run", rdreq, 1);
            if (i < 3) chk("start_latency_valid", m_valid, int'(i == 2));
        end
        cyc();
        chk("rdreq_stop", rdreq, 0);
        wait_idle(50);
        for (int i = 0; i < 5; i++) cyc();
        chk("thr_reads", n_rd - r0, 64);
        chk("thr_words", n_dlv - d0, 64);
        chk("thr_done_once", n_done - b0, 1);

        rmode = 1;
        r0 = n_rd; d0 = n_dlv; b0 = n_done;
        fill = nrd + 64;
        cyc();
        chk("bp_busy", busy, 1);
        wait_idle(1000);
        rmode = 0;
        chk("bp_reads", n_rd - r0, 64);
        chk("bp_words", n_dlv - d0, 64);
        chk("bp_done_once", n_done - b0, 1);

        r0 = n_rd; d0 = n_dlv; b0 = n_done;
        fill = nrd + 64;
        wait_dlv(d0 + 2, 20);
        rmode = 2;
        for (int i = 0; i < 8; i++) cyc();
        chk("stall_rdreq", rdreq, 0);
        chk("stall_valid", m_valid, 1);
        chk("stall_buffered", (n_rd - r0) - (n_dlv - d0), 4);
        chk("stall_delivered", n_dlv - d0, 2);
        rmode = 0;
        wait_idle(200);
        chk("stall_reads", n_rd - r0, 64);
        chk("stall_words", n_dlv - d0, 64);
        chk("stall_done_once", n_done - b0, 1);

        r0 = n_rd; d0 = n_dlv; b0 = n_done;
        fill = nrd + 2000;
        wait_dlv(d0 + 10, 40);
        en = 1'b0;
        wait_idle(200);
        chk("endrop_reads", n_rd - r0, 64);
        chk("endrop_words", n_dlv - d0, 64);
        chk("endrop_done_once", n_done - b0, 1);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("en_low_no_start", int'(rdreq || busy), 0);
        end

        r0 = n_rd_b; d0 = n_dlv_b; b0 = n_done_b;
        en_b = 1'b1;
        fill_b = nrd_b + 5;
        for (int i = 0; i < 40; i++) cyc();
        chk("b_reads", n_rd_b - r0, 5);
        chk("b_words", n_dlv_b - d0, 5);
        chk("b_bursts", n_done_b - b0, 5);

        fill_b = nrd_b + 5;
        for (int i = 0; i < 7; i++) cyc();
        do_reset(2, 1'b0);
        en_b = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("b_no_rd_after_rst", rdreq_b, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
